// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target that decodes register writes (and optionally
// reads) from an SCCB initiator. It oversamples sioc/siod with clk and emits
// one-cycle write strobes toward an external register file.
//
// Optional feature macro: SCCB_TARGET_READ_EN
//   defined   -> ID with R/W=1 is ACKed; the read states drive rd_data out.
//   undefined -> ID with R/W=1 is ignored like a foreign ID; rd_data is unused.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   sioc, siod_i  SCCB clock and data pin inputs
//   siod_oe       1 pulls the data pad low (open drain)
//   wr_valid      one-cycle write strobe, with wr_addr / wr_data
//   rd_addr       register pointer (read address, also write pointer)
//   rd_data       register file data, valid 1 clk after rd_addr changes
//   busy          high from an accepted START until STOP or ID mismatch
module sccb_target #(
    parameter logic [7:0]  SID        = 8'h60,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    localparam int unsigned FCNT_W = 4;
    localparam int unsigned BCNT_W = 4;
    localparam logic [FCNT_W-1:0] FILT_MAX  = FCNT_W'(FILTER_LEN - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(7);
`ifdef SCCB_TARGET_READ_EN
    localparam logic [BCNT_W-1:0] BYTE_DONE = BCNT_W'(8);
    localparam logic [BCNT_W-1:0] ACK_SEEN  = BCNT_W'(1);
`endif

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
`ifdef SCCB_TARGET_READ_EN
        RD_BYTE,
        RD_ACK,
`endif
        IGNORE
    } state_t;

    // Input conditioning state
    logic [1:0]        scl_sync_q, scl_sync_d;
    logic [1:0]        sda_sync_q, sda_sync_d;
    logic [FCNT_W-1:0] scl_cnt_q, scl_cnt_d;
    logic [FCNT_W-1:0] sda_cnt_q, sda_cnt_d;
    logic              scl_q, scl_d;
    logic              sda_q, sda_d;
    logic              scl_prev_q, sda_prev_q;

    // Protocol state
    state_t            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              oe_q, oe_d;
    logic              wr_valid_q, wr_valid_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
`ifdef SCCB_TARGET_READ_EN
    logic              rw_q, rw_d;
`endif

    logic       scl_rise_c, scl_fall_c, start_c, stop_c, id_ok_c;
    logic [7:0] byte_c;

    // Synchronizers and stability filters: a level is accepted once the
    // synchronized input has differed from it for FILTER_LEN cycles.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], sioc};
        sda_sync_d = {sda_sync_q[0], siod_i};
        scl_cnt_d  = '0;
        sda_cnt_d  = '0;
        scl_d      = scl_q;
        sda_d      = sda_q;
        if (scl_sync_q[1] != scl_q) begin
            if (scl_cnt_q >= FILT_MAX) scl_d = scl_sync_q[1];
            else                       scl_cnt_d = scl_cnt_q + 1'b1;
        end
        if (sda_sync_q[1] != sda_q) begin
            if (sda_cnt_q >= FILT_MAX) sda_d = sda_sync_q[1];
            else                       sda_cnt_d = sda_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            scl_prev_q <= scl_q;
            sda_prev_q <= sda_q;
        end
    end

    // Bus events from the filtered levels
    assign scl_rise_c = scl_q & ~scl_prev_q;
    assign scl_fall_c = ~scl_q & scl_prev_q;
    assign start_c    = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
    assign stop_c     = scl_q & scl_prev_q & ~sda_prev_q & sda_q;
    assign byte_c     = {shift_q, sda_q};

`ifdef SCCB_TARGET_READ_EN
    assign id_ok_c = (byte_c[7:1] == SID[7:1]);
`else
    assign id_ok_c = (byte_c[7:1] == SID[7:1]) && !byte_c[0];
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    // Protocol FSM. In the ACK states oe_q tells the two falling edges apart:
    // the first starts driving the ACK, the second ends the ACK bit.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
`ifdef SCCB_TARGET_READ_EN
        rw_d       = rw_q;
`endif
        if (stop_c) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            bcnt_d  = '0;
        end else if (start_c) begin
            state_d = ID;
            busy_d  = 1'b1;
            oe_d    = 1'b0;
            bcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, IGNORE: begin
                    oe_d = 1'b0;
                end
                ID, ADDR, DATA: begin
                    if (scl_rise_c) begin
                        shift_d = byte_c[6:0];
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == LAST_BIT) begin
                            bcnt_d = '0;
                            if (state_q == ID) begin
`ifdef SCCB_TARGET_READ_EN
                                rw_d = byte_c[0];
`endif
                                if (id_ok_c) begin
                                    state_d = ID_ACK;
                                end else begin
                                    state_d = IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == ADDR) begin
                                rd_addr_d = byte_c;
                                state_d   = ADDR_ACK;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = rd_addr_q;
                                wr_data_d  = byte_c;
                                rd_addr_d  = rd_addr_q + 8'd1;
                                state_d    = DATA_ACK;
                            end
                        end
                    end
                end
                ID_ACK, ADDR_ACK, DATA_ACK: begin
                    if (scl_fall_c) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d   = 1'b0;
                            bcnt_d = '0;
                            if (state_q == ID_ACK) begin
                                state_d = ADDR;
`ifdef SCCB_TARGET_READ_EN
                                if (rw_q) begin
                                    state_d = RD_BYTE;
                                    shift_d = rd_data[6:0];
                                    oe_d    = ~rd_data[7];
                                end
`endif
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end
`ifdef SCCB_TARGET_READ_EN
                RD_BYTE: begin
                    if (scl_rise_c) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end else if (scl_fall_c) begin
                        if (bcnt_q == BYTE_DONE) begin
                            oe_d    = 1'b0;
                            bcnt_d  = '0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d    = ~shift_q[6];
                            shift_d = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    // bcnt=1 marks an ACK seen; the next byte loads on the fall
                    if (scl_rise_c) begin
                        if (!sda_q) begin
                            rd_addr_d = rd_addr_q + 8'd1;
                            bcnt_d    = ACK_SEEN;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall_c && bcnt_q == ACK_SEEN) begin
                        shift_d = rd_data[6:0];
                        oe_d    = ~rd_data[7];
                        bcnt_d  = '0;
                        state_d = RD_BYTE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            shift_q    <= '0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
            rw_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
`ifdef SCCB_TARGET_READ_EN
            rw_q       <= rw_d;
`endif
        end
    end

    assign siod_oe  = oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB initiator driving sccb_target, with a
// transaction-level model of expected register writes and read data.
`timescale 1ns/1ps
module tb_sccb_target;

    localparam int T = 12;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sioc;
    logic       sda_m;
    logic       siod_i;
    logic       siod_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    logic [7:0]  rf [256];
    logic [7:0]  wd [8];
    logic [15:0] wr_q  [$];
    logic [15:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          consec   = 0;
    logic        wr_prev  = 1'b0;
    logic        oe_seen  = 1'b0;

    sccb_target #(.SID(8'h60), .FILTER_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sioc     (sioc),
        .siod_i   (siod_i),
        .siod_oe  (siod_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of initiator and target
    assign siod_i = sda_m & ~siod_oe;

    always @(posedge clk) rd_data <= rf[rd_addr];

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back({wr_addr, wr_data});
        if (wr_valid && wr_prev) consec++;
        wr_prev = wr_valid;
        if (siod_oe) oe_seen = 1'b1;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; clks(T);
        sioc  = 1'b1; clks(T);
        sda_m = 1'b0; clks(T);
        sioc  = 1'b0; clks(T);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(T);
        sioc  = 1'b1; clks(T);
        sda_m = 1'b1; clks(2*T);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int glitch_bit);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; clks(T);
            sioc  = 1'b1; clks(T);
            if (i == glitch_bit) begin
                sioc = 1'b0; clks(1);
                sioc = 1'b1;
            end
            clks(T);
            sioc = 1'b0; clks(T);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        send_bits(b, 8, glitch_bit);
        sda_m = 1'b1; clks(T);
        sioc  = 1'b1; clks(T);
        ack   = siod_i; clks(T);
        sioc  = 1'b0; clks(T);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; clks(T);
            sioc  = 1'b1; clks(T);
            b     = {b[6:0], siod_i}; clks(T);
            sioc  = 1'b0; clks(T);
        end
        sda_m = nack; clks(T);
        sioc  = 1'b1; clks(2*T);
        sioc  = 1'b0; clks(T);
    endtask

    // START, id, addr, n data bytes from wd[], STOP; any_nack = OR of ACK bits
    task automatic write_txn(input logic [7:0] addr, input int n, output logic any_nack);
        logic a;
        any_nack = 1'b0;
        bus_start();
        write_byte(8'h60, -1, a); any_nack |= a;
        write_byte(addr, -1, a);  any_nack |= a;
        for (int i = 0; i < n; i++) begin
            write_byte(wd[i], -1, a); any_nack |= a;
        end
        bus_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sioc = 1'b1; sda_m = 1'b1;
        clks(4);
        rst_n = 1'b1;
        clks(10);
        checks++; if (siod_oe !== 1'b0)  begin failures++; $display("FAIL reset_oe got=%b exp=0", siod_oe); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL reset_rd_addr got=%h exp=00", rd_addr); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        logic [15:0] g;
        wr_q.delete();
        bus_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start got=%b exp=1", busy); end
        write_byte(8'h60, -1, a0);
        write_byte(8'hFF, -1, a1);
        write_byte(8'h01, -1, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL single_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            g = wr_q.pop_front();
            checks++; if (g !== 16'hFF01) begin failures++; $display("FAIL single_write got=%h exp=ff01", g); end
        end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL single_busy_stop got=%b exp=0", busy); end
        checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL single_oe_stop got=%b exp=0", siod_oe); end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        wr_q.delete();
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'h42, -1, a0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
        write_byte(8'h10, -1, a1);
        write_byte(8'h55, -1, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL mismatch_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mismatch_oe got=%b exp=0", oe_seen); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL mismatch_count got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_burst();
        logic       nk;
        logic [7:0] addr, ptr;
        int         n;
        logic [15:0] g, e;
        for (int it = 0; it < 5; it++) begin
            wr_q.delete();
            exp_q.delete();
            if (it == 0) begin
                addr = 8'hFE; n = 3;
                wd[0] = 8'hAA; wd[1] = 8'hBB; wd[2] = 8'hCC;
            end else begin
                addr = 8'($urandom);
                n    = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) wd[i] = 8'($urandom);
            end
            ptr = addr;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({ptr, wd[i]});
                ptr = ptr + 8'd1;
            end
            write_txn(addr, n, nk);
            checks++; if (nk !== 1'b0) begin failures++; $display("FAIL burst_ack it=%0d got=%b exp=0", it, nk); end
            checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL burst_count it=%0d got=%0d exp=%0d", it, wr_q.size(), exp_q.size()); end
            while (wr_q.size() > 0 && exp_q.size() > 0) begin
                g = wr_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (g !== e) begin failures++; $display("FAIL burst_write it=%0d got=%h exp=%h", it, g, e); end
            end
            checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL burst_ptr it=%0d got=%h exp=%h", it, rd_addr, ptr); end
        end
    endtask

    task automatic test_read();
        logic       nk, a;
        logic [7:0] got, got2, addr;
        oe_seen = 1'b0;
`ifdef SCCB_TARGET_READ_EN
        rf[8'h0A] = 8'h5C;
        write_txn(8'h0A, 0, nk);
        checks++; if (rd_addr !== 8'h0A) begin failures++; $display("FAIL read_ptr got=%h exp=0a", rd_addr); end
        bus_start();
        write_byte(8'h61, -1, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL read_id_ack got=%b exp=0", a); end
        read_byte(1'b1, got);
        bus_stop();
        checks++; if (got !== 8'h5C) begin failures++; $display("FAIL read_byte got=%h exp=5c", got); end
        for (int it = 0; it < 3; it++) begin
            addr = 8'($urandom);
            write_txn(addr, 0, nk);
            bus_start();
            write_byte(8'h61, -1, a);
            read_byte(1'b0, got);
            read_byte(1'b1, got2);
            bus_stop();
            checks++; if (got !== rf[addr]) begin failures++; $display("FAIL read_rand0 it=%0d got=%h exp=%h", it, got, rf[addr]); end
            checks++; if (got2 !== rf[8'(addr + 8'd1)]) begin failures++; $display("FAIL read_rand1 it=%0d got=%h exp=%h", it, got2, rf[8'(addr + 8'd1)]); end
            checks++; if (rd_addr !== 8'(addr + 8'd1)) begin failures++; $display("FAIL read_ptr_end it=%0d got=%h exp=%h", it, rd_addr, 8'(addr + 8'd1)); end
        end
`else
        bus_start();
        write_byte(8'h61, -1, a);
        read_byte(1'b1, got);
        bus_stop();
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL noread_ack got=%b exp=1", a); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL noread_oe got=%b exp=0", oe_seen); end
        checks++; if (got !== 8'hFF) begin failures++; $display("FAIL noread_line got=%h exp=ff", got); end
        addr = 8'h00;
        got2 = 8'h00;
        nk   = 1'b0;
`endif
    endtask

    task automatic test_partial();
        logic        a, nk;
        logic [15:0] g;
        wr_q.delete();
        bus_start();
        write_byte(8'h60, -1, a);
        write_byte(8'h20, -1, a);
        send_bits(8'hA0, 4, -1);
        bus_stop();
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL partial_count got=%0d exp=0", wr_q.size()); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL partial_busy got=%b exp=0", busy); end
        wd[0] = 8'h77;
        write_txn(8'h20, 1, nk);
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL partial_next_count got=%0d exp=1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            g = wr_q.pop_front();
            checks++; if (g !== 16'h2077) begin failures++; $display("FAIL partial_next got=%h exp=2077", g); end
        end
    endtask

    task automatic test_repeated_start();
        logic        a0, a1, a2, a3;
        logic [15:0] g;
        wr_q.delete();
        bus_start();
        write_byte(8'h60, -1, a0);
        write_byte(8'h40, -1, a0);
        send_bits(8'hE0, 3, -1);
        bus_start();
        write_byte(8'h60, -1, a1);
        checks++; if (rd_addr !== 8'h40) begin failures++; $display("FAIL rstart_ptr got=%h exp=40", rd_addr); end
        write_byte(8'h50, -1, a2);
        write_byte(8'h99, -1, a3);
        bus_stop();
        checks++; if ({a1, a2, a3} !== 3'b000) begin failures++; $display("FAIL rstart_acks got=%b exp=000", {a1, a2, a3}); end
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL rstart_count got=%0d exp=1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            g = wr_q.pop_front();
            checks++; if (g !== 16'h5099) begin failures++; $display("FAIL rstart_write got=%h exp=5099", g); end
        end
    endtask

    task automatic test_glitch();
        logic        a;
        logic [15:0] g;
        wr_q.delete();
        bus_start();
        write_byte(8'h60, -1, a);
        write_byte(8'h30, -1, a);
        write_byte(8'h5A, 3, a);
        bus_stop();
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            g = wr_q.pop_front();
            checks++; if (g !== 16'h305A) begin failures++; $display("FAIL glitch_write got=%h exp=305a", g); end
        end
    endtask

    task automatic test_reset_in_ack();
        int waited;
        bus_start();
        send_bits(8'h60, 8, -1);
        sda_m  = 1'b1;
        waited = 0;
        while (siod_oe !== 1'b1 && waited < 4*T) begin
            clks(1);
            waited++;
        end
        checks++; if (siod_oe !== 1'b1) begin failures++; $display("FAIL rst_ack_drive got=%b exp=1", siod_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL rst_ack_release got=%b exp=0", siod_oe); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_ack_busy got=%b exp=0", busy); end
        sioc = 1'b1; sda_m = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(20);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
        test_reset();
        test_single_write();
        test_mismatch();
        test_burst();
        test_read();
        test_partial();
        test_repeated_start();
        test_glitch();
        test_reset_in_ack();
        test_single_write();
        checks++; if (consec != 0) begin failures++; $display("FAIL wr_valid_consecutive got=%0d exp=0", consec); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB/I2C target (responder) that decodes register-write and register-read transactions from an SCCB initiator on `sioc`/`siod`. It is the camera side of the configuration link the OV2640 initiator drives. It serves two purposes: a synthesizable sensor-register model for closed-loop simulation, and an on-chip configuration port for FPGA-resident register banks. It oversamples the bus with the system clock, emits one-cycle write strobes toward an external register file, and returns read data from it.

## Interface

Parameters:
- `SID`, `8'h60`: 7-bit device ID in bits [7:1]; bit 0 is ignored.
- `FILTER_LEN`, `3`: clk cycles a synchronized bus level must be stable before it is accepted (1–15).

Ports:
- `clk` in 1: system clock, 50 MHz nominal.
- `rst_n` in 1: asynchronous active-low reset.
- `sioc` in 1: SCCB clock from the initiator.
- `siod_i` in 1: SCCB data pin input.
- `siod_oe` out 1: 1 drives the pad low; the top level ties the pad to `siod_oe ? 1'b0 : 1'bz`.
- `wr_valid` out 1: one-cycle write strobe.
- `wr_addr` out 8: register address; valid while `wr_valid`=1.
- `wr_data` out 8: register data; valid while `wr_valid`=1.
- `rd_addr` out 8: read pointer into the external register file.
- `rd_data` in 8: register file data; must be valid 1 clk after `rd_addr` changes.
- `busy` out 1: high from an accepted START until STOP or ID mismatch.

## Operation

Input conditioning:
- `sioc` and `siod_i` each pass through a 2-flop synchronizer, then a stability filter of `FILTER_LEN` cycles.
- All events below are derived from the filtered levels `scl` and `sda`.

Bus events:
- START: `sda` falls while `scl`=1.
- STOP: `sda` rises while `scl`=1.
- Data bits are sampled MSB first on `scl` rising edges.
- The target changes `siod_oe` only on `scl` falling edges.

States:
- IDLE: wait for START.
- ID: shift 8 bits. If bits [7:1] match `SID[7:1]`, go to ID_ACK. Otherwise go to IGNORE with no ACK.
- ID_ACK: `siod_oe`=1 for one SCL period. Then go to ADDR if the R/W bit is 0, or to RD_BYTE if it is 1.
- ADDR: shift 8 bits, then ADDR_ACK. The pointer is loaded (`rd_addr` ← byte) when ADDR_ACK is entered.
- ADDR_ACK → DATA.
- DATA: shift 8 bits. On the 8th sample, `wr_valid`=1 for one clk with `wr_addr`=`rd_addr` and `wr_data`=byte. Then go to DATA_ACK.
- DATA_ACK: `rd_addr` increments, wrapping 8'hFF→8'h00. Then go to DATA. Further bytes are burst writes.
- RD_BYTE: on the `scl` falling edge that ends ID_ACK, load the shifter from `rd_data`. Drive `siod_oe` = ~bit on each falling edge (bit 0 → drive low, bit 1 → release). Release after the 8th bit.
- RD_ACK: sample the initiator bit. ACK (0): increment `rd_addr` and return to RD_BYTE. NACK (1): go to IGNORE.
- IGNORE: `siod_oe`=0 until the next START or STOP.

Boundary conditions:
- STOP in any state → IDLE, `busy`=0, `siod_oe`=0. A partial byte is discarded with no write.
- START in any state, including a repeated START mid-byte → ID. The bit counter is cleared and `rd_addr` is retained. This makes a 2-phase write (ID, ADDR, STOP) followed by a read (START, ID|1) return the addressed register.
- A STOP or START while `siod_oe`=1 releases the line in the same clk the event is detected.

## Timing

Reset values:
- `siod_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0.
- State is IDLE and the filters are preset to 1.
- Reset is asynchronous: asserting it mid-transfer releases `siod_oe` immediately.

Latencies:
- Pin edge to filtered event: 2 + `FILTER_LEN` clk.
- `wr_valid` asserts 1 clk after the filtered `scl` rise that samples data bit 0.
- `siod_oe` updates 1 clk after a filtered `scl` fall.

Rate limits:
- The filtered SCL high and low phases must each be ≥ `FILTER_LEN`+4 clk.
- `wr_valid` is never asserted on consecutive cycles. The minimum spacing is 9 SCL periods.

## Configuration

- `SCCB_TARGET_READ_EN` defined: ID with R/W=1 is ACKed and RD_BYTE/RD_ACK are implemented.
- Not defined: ID with R/W=1 is treated as a mismatch (no ACK, IGNORE). `rd_data` is unused. The read states are not synthesized. `rd_addr` still tracks the write pointer.

## Test plan

- START, 0x60, 0xFF, 0x01, STOP → three ACKs. Exactly one `wr_valid` with `wr_addr`=0xFF and `wr_data`=0x01. `busy` is low after STOP.
- START, 0x42, 0x10, 0x55, STOP → no ACK, `siod_oe` never high, no `wr_valid`.
- START, 0x60, 0xFE, 0xAA, 0xBB, 0xCC, STOP → writes (0xFE,0xAA), (0xFF,0xBB), (0x00,0xCC).
- With the read macro and a model register file holding 0x0A=0x5C: START 0x60 0x0A STOP, then START 0x61 with initiator NACK, then STOP → the bits driven on SDA read 0x5C MSB first.
- START, 0x60, 0x20, 4 bits of data, STOP → no `wr_valid` and return to IDLE. The next full write is accepted normally.
- A 1-clk-wide low glitch on `sioc` during DATA with `FILTER_LEN`=3 → no extra bit is shifted and the written value is unchanged. Asserting `rst_n`=0 during ID_ACK drops `siod_oe` in the same cycle.
